// File: rtl/dmx_frame_receiver.sv
// DMX512 frame receiver: input synchroniser, majority-vote bit sampling,
// BREAK/MAB detection and slot reception with frame-level status pulses.
module dmx_frame_receiver #(
  parameter int CLK_FREQ     = 20_000_000,
  parameter int BAUD_RATE    = 250_000,
  parameter int STOP_BITS    = 2,
  parameter int BREAK_MIN_US = 88,
  parameter int MAB_MIN_US   = 8,
  parameter int SLOT_TMO_US  = 44,
  parameter int MAX_SLOTS    = 512,
  localparam int SLOT_W      = $clog2(MAX_SLOTS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              rx_in,
  output logic              slot_valid,
  output logic [7:0]        slot_data,
  output logic [SLOT_W-1:0] slot_index,
  output logic              frame_start,
  output logic              frame_end,
  output logic [SLOT_W-1:0] slot_count,
  output logic              frame_err,
  output logic              short_break
);

  // Timing constants in clock cycles
  localparam int BIT_TIME  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT  = BIT_TIME / 2;
  localparam int BREAK_MIN = int'((longint'(BREAK_MIN_US) * longint'(CLK_FREQ)) / longint'(1_000_000));
  localparam int MAB_MIN   = int'((longint'(MAB_MIN_US) * longint'(CLK_FREQ)) / longint'(1_000_000));
  localparam int SLOT_TMO  = int'((longint'(SLOT_TMO_US) * longint'(CLK_FREQ)) / longint'(1_000_000));
  localparam int T_MAX_A   = (BREAK_MIN > SLOT_TMO) ? BREAK_MIN : SLOT_TMO;
  localparam int T_MAX_B   = (MAB_MIN > BIT_TIME) ? MAB_MIN : BIT_TIME;
  localparam int T_MAX     = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  // One spare bit so saturating counters always reach every threshold
  localparam int CNT_W     = $clog2(T_MAX + 1) + 1;

  localparam logic [CNT_W-1:0]  BREAK_MIN_C   = CNT_W'(BREAK_MIN);
  localparam logic [CNT_W-1:0]  MAB_MIN_C     = CNT_W'(MAB_MIN);
  localparam logic [CNT_W-1:0]  SLOT_TMO_C    = CNT_W'(SLOT_TMO);
  localparam logic [CNT_W-1:0]  BIT_TIME_C    = CNT_W'(BIT_TIME);
  localparam logic [CNT_W-1:0]  FIRST_SMP_C   = CNT_W'(HALF_BIT + 1);
  localparam logic [1:0]        LAST_STOP_C   = 2'(STOP_BITS - 1);
  localparam logic [SLOT_W-1:0] MAX_IDX_C     = SLOT_W'(MAX_SLOTS);

  typedef enum logic [3:0] {
    S_WAIT_BREAK,
    S_BREAK,
    S_MAB,
    S_START,
    S_DATA,
    S_STOP,
    S_INTERSLOT,
    S_END_FRAME,
    S_OVF_END,
    S_IGNORE
  } state_t;

  state_t state, state_next;

  logic              rx_meta, rx_s, rx_d1, rx_d2;
  logic [CNT_W-1:0]  low_run, high_run, tmr;
  logic [2:0]        bit_cnt;
  logic [1:0]        stop_cnt;
  logic [7:0]        shift;
  logic [SLOT_W-1:0] idx, last_valid;
  logic              frame_active;
  logic              vote, timed, sample_due;
  logic              sv_next, fs_next, fe_next, err_next, sb_next;

  // Majority of the samples one clock before, at and after the bit centre
  assign vote       = (rx_d2 & rx_d1) | (rx_d2 & rx_s) | (rx_d1 & rx_s);
  assign timed      = (state == S_START) || (state == S_DATA) || (state == S_STOP);
  assign sample_due = (state == S_START) ? (tmr == FIRST_SMP_C) : (tmr == BIT_TIME_C);
  assign slot_index = idx;

  // Two-flop synchroniser plus two history taps for the vote, idle high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d1   <= 1'b1;
      rx_d2   <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_d1   <= rx_s;
      rx_d2   <= rx_d1;
    end
  end

  // Saturating run lengths of the current line level; a BREAK that starts
  // inside a failed slot is therefore measured from its true beginning
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_run  <= '0;
      high_run <= '0;
    end else if (!en) begin
      low_run  <= '0;
      high_run <= '0;
    end else if (rx_s) begin
      low_run  <= '0;
      if (high_run != '1) high_run <= high_run + 1'b1;
    end else begin
      high_run <= '0;
      if (low_run != '1) low_run <= low_run + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT_BREAK;
    else        state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      S_END_FRAME: state_next = S_WAIT_BREAK;
      S_OVF_END:   state_next = en ? S_IGNORE : S_WAIT_BREAK;
      default: begin
        if (!en) begin
          state_next = frame_active ? S_END_FRAME : S_WAIT_BREAK;
        end else begin
          case (state)
            S_WAIT_BREAK: if (!rx_s) state_next = S_BREAK;
            S_BREAK:      if (rx_s) state_next = (low_run >= BREAK_MIN_C) ? S_MAB : S_WAIT_BREAK;
            S_MAB:        if (!rx_s) state_next = (high_run >= MAB_MIN_C) ? S_START : S_BREAK;
            S_START: begin
              if (sample_due) begin
                if (!vote)             state_next = S_DATA;
                else if (frame_active) state_next = S_END_FRAME;
                else                   state_next = S_WAIT_BREAK;
              end
            end
            S_DATA:       if (sample_due && bit_cnt == 3'd7) state_next = S_STOP;
            S_STOP: begin
              if (sample_due) begin
                if (!vote)                          state_next = S_END_FRAME;
                else if (stop_cnt == LAST_STOP_C)   state_next = (idx == MAX_IDX_C) ? S_OVF_END : S_INTERSLOT;
              end
            end
            S_INTERSLOT: begin
              if (!rx_s)                    state_next = S_START;
              else if (tmr >= SLOT_TMO_C)   state_next = S_END_FRAME;
            end
            S_IGNORE:     if (low_run >= BREAK_MIN_C) state_next = S_BREAK;
            default:      state_next = S_WAIT_BREAK;
          endcase
        end
      end
    endcase
  end

  // Output pulse decode; frame_err and frame_end never share a clock
  always_comb begin
    sv_next  = 1'b0;
    fs_next  = 1'b0;
    fe_next  = 1'b0;
    err_next = 1'b0;
    sb_next  = 1'b0;
    if (en) begin
      sv_next  = (state == S_STOP) && sample_due && vote && (stop_cnt == LAST_STOP_C);
      fs_next  = (state == S_START) && sample_due && !vote && (idx == '0);
      err_next = ((state == S_START) && sample_due && vote) ||
                 ((state == S_STOP) && sample_due && !vote);
      sb_next  = (state == S_BREAK) && rx_s && (low_run < BREAK_MIN_C);
    end
    fe_next = frame_active && ((state == S_END_FRAME) || (state == S_OVF_END));
  end

  // Bit timer, shift register, slot index and frame bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr          <= '0;
      bit_cnt      <= '0;
      stop_cnt     <= '0;
      shift        <= '0;
      idx          <= '0;
      last_valid   <= '0;
      frame_active <= 1'b0;
    end else begin
      if (state_next != state || (timed && sample_due)) tmr <= CNT_W'(1);
      else if (tmr != '1)                                tmr <= tmr + 1'b1;

      if (state == S_START) bit_cnt <= '0;
      else if (state == S_DATA && sample_due) begin
        bit_cnt <= bit_cnt + 1'b1;
        shift   <= {vote, shift[7:1]};
      end

      if (state != S_STOP)     stop_cnt <= '0;
      else if (sample_due)     stop_cnt <= stop_cnt + 1'b1;

      if (state == S_MAB && state_next == S_START)            idx <= '0;
      else if (state == S_INTERSLOT && state_next == S_START) idx <= idx + 1'b1;

      if (fs_next)      last_valid <= '0;
      else if (sv_next) last_valid <= idx;

      if (fe_next)      frame_active <= 1'b0;
      else if (fs_next) frame_active <= 1'b1;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid  <= 1'b0;
      slot_data   <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      slot_count  <= '0;
      frame_err   <= 1'b0;
      short_break <= 1'b0;
    end else begin
      slot_valid  <= sv_next;
      frame_start <= fs_next;
      frame_end   <= fe_next;
      frame_err   <= err_next;
      short_break <= sb_next;
      if (sv_next) slot_data  <= shift;
      if (fe_next) slot_count <= last_valid;
    end
  end

endmodule

// File: tb/tb_dmx_frame_receiver.sv
// Scoreboard bench for dmx_frame_receiver: three builds (default, 1 stop bit
// at 115200, and a fast 8-slot build for overflow) driven by directed frames.
`timescale 1ns/1ps
module tb_dmx_frame_receiver;

  localparam int K_SLOT = 0;
  localparam int K_FS   = 1;
  localparam int K_FE   = 2;
  localparam int K_ERR  = 3;
  localparam int K_SB   = 4;

  localparam int BT_A = 80;   // 20 MHz / 250000
  localparam int BT_B = 173;  // 20 MHz / 115200
  localparam int BT_C = 8;    // 20 MHz / 2500000

  typedef struct {
    int kind;
    int a;
    int b;
  } evt_t;

  evt_t q_a[$];
  evt_t q_b[$];
  evt_t q_c[$];

  int checks = 0;
  int failures = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] en;
  logic [2:0] rx;

  logic       sv_a, fs_a, fe_a, err_a, sb_a;
  logic [7:0] data_a;
  logic [9:0] idx_a, cnt_a;
  logic       sv_b, fs_b, fe_b, err_b, sb_b;
  logic [7:0] data_b;
  logic [9:0] idx_b, cnt_b;
  logic       sv_c, fs_c, fe_c, err_c, sb_c;
  logic [7:0] data_c;
  logic [3:0] idx_c, cnt_c;

  always #25 clk = ~clk;

  dmx_frame_receiver dut_a (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .rx_in(rx[0]),
    .slot_valid(sv_a), .slot_data(data_a), .slot_index(idx_a),
    .frame_start(fs_a), .frame_end(fe_a), .slot_count(cnt_a),
    .frame_err(err_a), .short_break(sb_a)
  );

  dmx_frame_receiver #(.BAUD_RATE(115_200), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .rx_in(rx[1]),
    .slot_valid(sv_b), .slot_data(data_b), .slot_index(idx_b),
    .frame_start(fs_b), .frame_end(fe_b), .slot_count(cnt_b),
    .frame_err(err_b), .short_break(sb_b)
  );

  dmx_frame_receiver #(.BAUD_RATE(2_500_000), .MAX_SLOTS(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en[2]), .rx_in(rx[2]),
    .slot_valid(sv_c), .slot_data(data_c), .slot_index(idx_c),
    .frame_start(fs_c), .frame_end(fe_c), .slot_count(cnt_c),
    .frame_err(err_c), .short_break(sb_c)
  );

  task automatic expect_evt(input int inst, input int kind, input int a, input int b);
    evt_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    case (inst)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic observe(input int inst, input int kind, input int a, input int b);
    evt_t e;
    bit   have;
    have   = 1'b0;
    e.kind = -1;
    e.a    = 0;
    e.b    = 0;
    case (inst)
      0:       if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
      1:       if (q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
      default: if (q_c.size() > 0) begin e = q_c.pop_front(); have = 1'b1; end
    endcase
    checks++;
    if (!have) begin
      failures++;
      $display("FAIL unexpected_event dut=%0d got kind=%0d a=%0h b=%0h required none", inst, kind, a, b);
    end else if (e.kind != kind || e.a != a || e.b != b) begin
      failures++;
      $display("FAIL event dut=%0d got kind=%0d a=%0h b=%0h required kind=%0d a=%0h b=%0h",
               inst, kind, a, b, e.kind, e.a, e.b);
    end else begin
      $display("ok event dut=%0d kind=%0d a=%0h b=%0h", inst, kind, a, b);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, want);
    end else begin
      $display("ok %s = %0h", name, got);
    end
  endtask

  // Monitor: every output pulse pops and compares one expected event
  always @(negedge clk) begin
    if (sv_a)  observe(0, K_SLOT, int'(idx_a), int'(data_a));
    if (fs_a)  observe(0, K_FS, 0, 0);
    if (fe_a)  observe(0, K_FE, int'(cnt_a), 0);
    if (err_a) observe(0, K_ERR, 0, 0);
    if (sb_a)  observe(0, K_SB, 0, 0);
    if (sv_b)  observe(1, K_SLOT, int'(idx_b), int'(data_b));
    if (fs_b)  observe(1, K_FS, 0, 0);
    if (fe_b)  observe(1, K_FE, int'(cnt_b), 0);
    if (err_b) observe(1, K_ERR, 0, 0);
    if (sb_b)  observe(1, K_SB, 0, 0);
    if (sv_c)  observe(2, K_SLOT, int'(idx_c), int'(data_c));
    if (fs_c)  observe(2, K_FS, 0, 0);
    if (fe_c)  observe(2, K_FE, int'(cnt_c), 0);
    if (err_c) observe(2, K_ERR, 0, 0);
    if (sb_c)  observe(2, K_SB, 0, 0);
  end

  task automatic hold(input int inst, input logic lvl, input int n);
    rx[inst] = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_slot(input int inst, input int bt, input logic [7:0] data,
                           input int nstop, input int glitch_bit, input bit bad_stop);
    logic b;
    hold(inst, 1'b0, bt);
    for (int i = 0; i < 8; i++) begin
      b = data[i];
      if (i == glitch_bit) begin
        hold(inst, b, bt / 2);
        hold(inst, ~b, 1);
        hold(inst, b, bt - bt / 2 - 1);
      end else begin
        hold(inst, b, bt);
      end
    end
    for (int s = 0; s < nstop; s++) hold(inst, ~bad_stop, bt);
  endtask

  task automatic begin_frame(input int inst);
    hold(inst, 1'b0, 1900);  // 95 us BREAK
    hold(inst, 1'b1, 240);   // 12 us MAB
  endtask

  initial begin
    repeat (99_000) @(posedge clk);
    $display("FAIL watchdog cycle budget exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en    = 3'b111;
    rx    = 3'b111;
    repeat (4) @(posedge clk);
    #1;
    check_val("reset_slot_valid", int'(sv_a), 0);
    check_val("reset_slot_index", int'(idx_a), 0);
    rst_n = 1'b1;
    hold(0, 1'b1, 20);
    check_val("idle_slot_count", int'(cnt_a), 0);
    check_val("idle_slot_data", int'(data_a), 0);

    // Basic frame: start code plus three slots, terminated by idle timeout
    expect_evt(0, K_FS, 0, 0);
    expect_evt(0, K_SLOT, 0, 8'h00);
    expect_evt(0, K_SLOT, 1, 8'h11);
    expect_evt(0, K_SLOT, 2, 8'h22);
    expect_evt(0, K_SLOT, 3, 8'hFF);
    expect_evt(0, K_FE, 3, 0);
    begin_frame(0);
    send_slot(0, BT_A, 8'h00, 2, -1, 1'b0);
    send_slot(0, BT_A, 8'h11, 2, -1, 1'b0);
    send_slot(0, BT_A, 8'h22, 2, -1, 1'b0);
    send_slot(0, BT_A, 8'hFF, 2, -1, 1'b0);
    hold(0, 1'b1, 1000);

    // 50 us low is too short for a BREAK, then a normal frame
    expect_evt(0, K_SB, 0, 0);
    hold(0, 1'b0, 1000);
    hold(0, 1'b1, 200);
    expect_evt(0, K_FS, 0, 0);
    expect_evt(0, K_SLOT, 0, 8'h00);
    expect_evt(0, K_SLOT, 1, 8'h5A);
    expect_evt(0, K_FE, 1, 0);
    begin_frame(0);
    send_slot(0, BT_A, 8'h00, 2, -1, 1'b0);
    send_slot(0, BT_A, 8'h5A, 2, -1, 1'b0);
    hold(0, 1'b1, 1000);

    // Slot 2 stop bit low and the line stays low: error, end, new BREAK
    expect_evt(0, K_FS, 0, 0);
    expect_evt(0, K_SLOT, 0, 8'h00);
    expect_evt(0, K_SLOT, 1, 8'h11);
    expect_evt(0, K_ERR, 0, 0);
    expect_evt(0, K_FE, 1, 0);
    expect_evt(0, K_FS, 0, 0);
    expect_evt(0, K_SLOT, 0, 8'h00);
    expect_evt(0, K_SLOT, 1, 8'h5A);
    expect_evt(0, K_FE, 1, 0);
    begin_frame(0);
    send_slot(0, BT_A, 8'h00, 2, -1, 1'b0);
    send_slot(0, BT_A, 8'h11, 2, -1, 1'b0);
    send_slot(0, BT_A, 8'h22, 2, -1, 1'b1);
    hold(0, 1'b0, 2000);
    hold(0, 1'b1, 240);
    send_slot(0, BT_A, 8'h00, 2, -1, 1'b0);
    send_slot(0, BT_A, 8'h5A, 2, -1, 1'b0);
    hold(0, 1'b1, 1000);
    check_val("slot_count_after_err_frame", int'(cnt_a), 1);

    // One-clock glitch at the centre of data bit 2 is voted out
    expect_evt(0, K_FS, 0, 0);
    expect_evt(0, K_SLOT, 0, 8'h00);
    expect_evt(0, K_SLOT, 1, 8'hA5);
    expect_evt(0, K_FE, 1, 0);
    begin_frame(0);
    send_slot(0, BT_A, 8'h00, 2, -1, 1'b0);
    send_slot(0, BT_A, 8'hA5, 2, 2, 1'b0);
    hold(0, 1'b1, 1000);

    // Enable dropped mid-slot ends the active frame
    expect_evt(0, K_FS, 0, 0);
    expect_evt(0, K_SLOT, 0, 8'h00);
    expect_evt(0, K_SLOT, 1, 8'h33);
    expect_evt(0, K_FE, 1, 0);
    begin_frame(0);
    send_slot(0, BT_A, 8'h00, 2, -1, 1'b0);
    send_slot(0, BT_A, 8'h33, 2, -1, 1'b0);
    hold(0, 1'b0, BT_A);
    hold(0, 1'b1, BT_A);
    en[0] = 1'b0;
    hold(0, 1'b1, 20);
    en[0] = 1'b1;
    hold(0, 1'b1, 300);

    // Overflow on the 8-slot build: slots 9 and 10 are ignored
    expect_evt(2, K_FS, 0, 0);
    for (int i = 0; i <= 8; i++) expect_evt(2, K_SLOT, i, (i * 8'h11) & 8'hFF);
    expect_evt(2, K_FE, 8, 0);
    begin_frame(2);
    for (int i = 0; i < 11; i++) send_slot(2, BT_C, 8'((i * 8'h11) & 8'hFF), 2, -1, 1'b0);
    hold(2, 1'b1, 1000);
    expect_evt(2, K_FS, 0, 0);
    expect_evt(2, K_SLOT, 0, 8'h00);
    expect_evt(2, K_SLOT, 1, 8'hC3);
    expect_evt(2, K_FE, 1, 0);
    begin_frame(2);
    send_slot(2, BT_C, 8'h00, 2, -1, 1'b0);
    send_slot(2, BT_C, 8'hC3, 2, -1, 1'b0);
    hold(2, 1'b1, 1000);

    // One stop bit at 115200, then reset in the middle of a slot
    expect_evt(1, K_FS, 0, 0);
    expect_evt(1, K_SLOT, 0, 8'h00);
    expect_evt(1, K_SLOT, 1, 8'h3C);
    expect_evt(1, K_FE, 1, 0);
    begin_frame(1);
    send_slot(1, BT_B, 8'h00, 1, -1, 1'b0);
    send_slot(1, BT_B, 8'h3C, 1, -1, 1'b0);
    hold(1, 1'b1, 1000);
    check_val("b_slot_count", int'(cnt_b), 1);
    expect_evt(1, K_FS, 0, 0);
    expect_evt(1, K_SLOT, 0, 8'h00);
    begin_frame(1);
    send_slot(1, BT_B, 8'h00, 1, -1, 1'b0);
    hold(1, 1'b0, BT_B);
    hold(1, 1'b1, 2 * BT_B);
    check_val("b_index_before_reset", int'(idx_b), 1);
    rst_n = 1'b0;
    hold(1, 1'b1, 3);
    check_val("b_reset_slot_index", int'(idx_b), 0);
    check_val("b_reset_slot_count", int'(cnt_b), 0);
    check_val("b_reset_frame_end", int'(fe_b), 0);
    rst_n = 1'b1;
    hold(1, 1'b1, 1000);
    check_val("b_after_reset_slot_count", int'(cnt_b), 0);

    check_val("queue_a_drained", q_a.size(), 0);
    check_val("queue_b_drained", q_b.size(), 0);
    check_val("queue_c_drained", q_c.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
